dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares BRAM port B (the data port of the unified instruction/data memory) between two requesters.
- Requester 0 is the CPU FSM data interface (read/write).
- Requester 1 is the debug/display memory reader driven by show_mem (read-only).
- The CPU has priority, and a starvation counter guarantees forward progress for the debug reader. The block tracks the 1-cycle synchronous BRAM read latency and routes returned data to the correct requester.

Parameters:
ADDR_WIDTH, 9, BRAM word-address width
DATA_WIDTH, 16, data word width
MAX_WAIT, 4, consecutive denied debug cycles before the debug reader is forced to win (legal range 1..15)

Ports:
clk  in  1  system clock (same clock as the BRAM)
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_WIDTH  CPU read data
dbg_req  in  1  debug read request; held with dbg_addr stable until dbg_gnt
dbg_addr  in  ADDR_WIDTH  debug word address
dbg_gnt  out  1  debug read issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_WIDTH  debug read data
mem_en  out  1  BRAM port B enable
mem_we  out  1  BRAM port B write enable
mem_addr  out  ADDR_WIDTH  BRAM port B address
mem_din  out  DATA_WIDTH  BRAM port B write data
mem_dout  in  DATA_WIDTH  BRAM port B read data (valid the cycle after a read is issued)
conflict_cnt  out  16  saturating count of contended cycles

Behaviour:

Grant logic (combinational from req plus registered state):
- Only cpu_req: cpu_gnt=1.
- Only dbg_req: dbg_gnt=1.
- Both requesting: CPU wins unless wait_q == MAX_WAIT, in which case debug wins.
- At most one gnt per cycle. Each gnt issues exactly one access.
- A requester may deassert req without a grant; nothing is issued for it.

Port mux:
- mem_en = cpu_gnt | dbg_gnt.
- Debug grants force mem_we=0 and mem_din=0.
- CPU grants drive mem_we=cpu_we, mem_addr=cpu_addr, mem_din=cpu_wdata.
- With no grant: mem_we=0, mem_addr=0, mem_din=0.

Registered state:
- rd_pend_q: 2-bit one-hot {dbg, cpu}, set on a granted read.
- wait_q: 4-bit starvation counter.
- cpu_hold_q, dbg_hold_q: DATA_WIDTH-wide data holding registers.
- conflict_q: 16-bit conflict counter.

Read return:
- cpu_rvalid = rd_pend_q[0] and dbg_rvalid = rd_pend_q[1]; both are 1-cycle pulses exactly one cycle after the grant.
- cpu_rdata = cpu_rvalid ? mem_dout : cpu_hold_q. dbg_rdata follows the same rule with dbg_hold_q.
- Each holding register captures mem_dout when its rvalid is high, so rdata stays stable until the next rvalid for that requester.
- CPU writes produce no rvalid.
- Back-to-back reads (one every cycle) are fully pipelined.

wait_q:
- Increments by 1 each cycle dbg_req=1 and dbg_gnt=0, saturating at MAX_WAIT.
- Clears to 0 when dbg_gnt=1 or dbg_req=0.

conflict_q:
- Increments when cpu_req & dbg_req, saturating at 16'hFFFF.
- conflict_cnt = conflict_q.

Reset (asynchronous, active-low):
- All registers clear to 0, so rvalids, holds, wait and count are all 0.
- Grant and mem outputs are 0 while rst_n=0, even if reqs are high.
- Reset asserted mid-read: the pending rvalid is dropped and is never delivered after release.

Test Plan:
- CPU write 16'hBEEF to addr 9'h010, then CPU read of 9'h010: cpu_gnt each cycle; cpu_rvalid one cycle after the read grant with cpu_rdata=16'hBEEF; dbg_rvalid stays 0; cpu_rdata holds 16'hBEEF afterward.
- dbg_req alone at 9'h020 (preloaded 16'h1234): dbg_gnt same cycle, mem_we=0, dbg_rvalid next cycle with dbg_rdata=16'h1234.
- cpu_req and dbg_req held high continuously with MAX_WAIT=4: CPU granted 4 cycles, debug granted on the 5th, then CPU 4 more. conflict_cnt increments every cycle (5 after 5 cycles).
- Pipelined CPU reads to 9'h000, 9'h001, 9'h002 on consecutive cycles: three consecutive cpu_rvalid pulses with the matching words in order.
- rst_n pulsed low the cycle after a CPU read grant: no cpu_rvalid afterward. All outputs 0 during reset, conflict_cnt=0 after release.
- conflict_q preloaded near saturation (force) with continued contention: conflict_cnt sticks at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester handshakes, the BRAM port B pins and the conflict counter.
// The arbiter sits on the slave side; the environment (CPU, debug reader, BRAM) on the master side.
`timescale 1ns/1ps
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  dbg_req;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [15:0]           conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_din, conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_din, conflict_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// BRAM port B arbiter: CPU has priority, a starvation counter forces the debug reader through,
// and the 1-cycle read latency is tracked so returned data reaches the right requester.
`timescale 1ns/1ps
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0]            r_rd_pend;
  logic [3:0]            r_wait;
  logic [DATA_WIDTH-1:0] r_cpu_hold;
  logic [DATA_WIDTH-1:0] r_dbg_hold;
  logic [15:0]           r_conflict;

  logic w_dbg_win;
  logic w_cpu_gnt;
  logic w_dbg_gnt;
  logic w_conflict;

  // Grants are gated by rst_n so nothing reaches the BRAM while reset is held.
  assign w_dbg_win  = bus.dbg_req & (~bus.cpu_req | (r_wait == MAX_WAIT_C));
  assign w_dbg_gnt  = rst_n & w_dbg_win;
  assign w_cpu_gnt  = rst_n & bus.cpu_req & ~w_dbg_win;
  assign w_conflict = bus.cpu_req & bus.dbg_req;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (w_cpu_gnt) begin
      bus.mem_we   = bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
    end else if (w_dbg_gnt) begin
      bus.mem_addr = bus.dbg_addr;
    end
  end

  assign bus.mem_en       = w_cpu_gnt | w_dbg_gnt;
  assign bus.cpu_gnt      = w_cpu_gnt;
  assign bus.dbg_gnt      = w_dbg_gnt;
  assign bus.cpu_rvalid   = r_rd_pend[0];
  assign bus.dbg_rvalid   = r_rd_pend[1];
  assign bus.cpu_rdata    = r_rd_pend[0] ? bus.mem_dout : r_cpu_hold;
  assign bus.dbg_rdata    = r_rd_pend[1] ? bus.mem_dout : r_dbg_hold;
  assign bus.conflict_cnt = r_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= '0;
      r_wait     <= '0;
      r_cpu_hold <= '0;
      r_dbg_hold <= '0;
      r_conflict <= '0;
    end else begin
      r_rd_pend <= {w_dbg_gnt, w_cpu_gnt & ~bus.cpu_we};
      if (r_rd_pend[0]) r_cpu_hold <= bus.mem_dout;
      if (r_rd_pend[1]) r_dbg_hold <= bus.mem_dout;
      // Starvation counter only runs while debug is asking and being refused.
      if (bus.dbg_req && !w_dbg_gnt) begin
        if (r_wait != MAX_WAIT_C) r_wait <= r_wait + 4'd1;
      end else begin
        r_wait <= '0;
      end
      if (w_conflict && (r_conflict != 16'hFFFF)) r_conflict <= r_conflict + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized + directed bench: a reference model predicts grants, bus pins and read data;
// a separate monitor pops expected read words whenever an rvalid appears.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment BRAM: synchronous read, write on enable
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= bram[bus.mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dbg_q[$];
  logic [DW-1:0] last_cpu, last_dbg;
  int m_wait, m_conf;
  int n_checks = 0, n_errors = 0;
  bit stop_mon = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cpu_q.delete(); dbg_q.delete();
    last_cpu = '0; last_dbg = '0;
    m_wait = 0; m_conf = 0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic cycle(input logic c, input logic cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cw, input logic d, input logic [AW-1:0] da,
                       output logic gc, output logic gd);
    logic [AW-1:0] e_addr;
    @(negedge clk);
    bus.cpu_req = c; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cw;
    bus.dbg_req = d; bus.dbg_addr = da;
    #1;
    if (!rst_n) begin
      gc = 1'b0; gd = 1'b0;
    end else begin
      gd = d && (!c || m_wait == MAX_WAIT);
      gc = c && !gd;
    end
    e_addr = gc ? ca : (gd ? da : '0);
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(gc));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(gd));
    chk("mem_en", 32'(bus.mem_en), 32'(gc | gd));
    chk("mem_we", 32'(bus.mem_we), 32'(gc & cwe));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_din", 32'(bus.mem_din), gc ? 32'(cw) : 32'd0);
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
    if (rst_n) begin
      if (gc) begin
        if (cwe) ref_mem[ca] = cw;
        else     cpu_q.push_back(ref_mem[ca]);
      end
      if (gd) dbg_q.push_back(ref_mem[da]);
      if (d && !gd) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else          m_wait = 0;
      if (c && d && m_conf < 65535) m_conf++;
    end
  endtask

  // Monitor: read data appears one cycle after its grant
  initial begin
    logic [DW-1:0] e;
    while (!stop_mon) begin
      @(posedge clk); #2;
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
        else begin e = cpu_q.pop_front(); chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e)); last_cpu = e; end
      end else chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(last_cpu));
      if (bus.dbg_rvalid) begin
        if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'd1, 32'd0);
        else begin e = dbg_q.pop_front(); chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(e)); last_dbg = e; end
      end else chk("dbg_rdata_hold", 32'(bus.dbg_rdata), 32'(last_dbg));
    end
  end

  initial begin
    logic gc, gd;
    logic c_act, c_we, d_act;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wd, v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      bram[i] = v; ref_mem[i] = v;
    end
    bram[9'h020] = 16'h1234; ref_mem[9'h020] = 16'h1234;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_addr = '0; bus.mem_dout = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // CPU write then read back
    cycle(1, 1, 9'h010, 16'hBEEF, 0, '0, gc, gd);
    cycle(1, 0, 9'h010, 16'h0000, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    chk("cpu_rdata_beef", 32'(bus.cpu_rdata), 32'h0000BEEF);

    // Debug read alone
    cycle(0, 0, '0, '0, 1, 9'h020, gc, gd);
    chk("dbg_alone_gnt", 32'(bus.dbg_gnt), 32'd1);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    chk("dbg_rdata_1234", 32'(bus.dbg_rdata), 32'h00001234);

    // Pipelined CPU reads
    for (int i = 0; i < 3; i++) cycle(1, 0, AW'(i), '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);

    // Reset right after a CPU read grant: the pending read must vanish
    cycle(1, 0, 9'h005, '0, 0, '0, gc, gd);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    cycle(1, 0, 9'h007, '0, 1, 9'h008, gc, gd);
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_cpu_rvalid_drop", 32'(bus.cpu_rvalid), 32'd0);
    @(negedge clk);
    bus.cpu_req = 0; bus.dbg_req = 0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_conflict", 32'(bus.conflict_cnt), 32'd0);

    // Continuous contention: CPU x4, debug, CPU x4
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 9'h030, '0, 1, 9'h020, gc, gd);
      chk("contend_dbg_gnt", 32'(bus.dbg_gnt), (i == 4) ? 32'd1 : 32'd0);
      chk("contend_conflict", 32'(bus.conflict_cnt), 32'(i));
    end
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);

    // Randomized traffic with request-hold protocol
    c_act = 0; d_act = 0; c_we = 0; c_addr = '0; c_wd = '0; d_addr = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!c_act || $urandom_range(0, 15) == 0) begin
        c_act = ($urandom_range(0, 2) != 0);
        c_we = ($urandom_range(0, 2) == 0);
        c_addr = AW'($urandom_range(0, 31));
        c_wd = DW'($urandom);
      end
      if (!d_act || $urandom_range(0, 15) == 0) begin
        d_act = ($urandom_range(0, 1) != 0);
        d_addr = AW'($urandom_range(0, 31));
      end
      cycle(c_act, c_we, c_addr, c_wd, d_act, d_addr, gc, gd);
      if (gc) c_act = 0;
      if (gd) d_act = 0;
    end

    // Conflict counter saturation
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    force dut.r_conflict = 16'hFFFC;
    m_conf = 16'hFFFC;
    @(posedge clk); #1;
    release dut.r_conflict;
    for (int i = 0; i < 6; i++) cycle(1, 0, 9'h003, '0, 1, 9'h004, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    chk("conflict_saturated", 32'(bus.conflict_cnt), 32'h0000FFFF);

    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    cycle(0, 0, '0, '0, 0, '0, gc, gd);
    stop_mon = 1;
    @(posedge clk); #3;
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
